// File: rtl/image_loader.sv
// Thresholds a row-major grayscale pixel stream into a LENGTH x WIDTH binary frame
// and publishes each completed frame atomically, with an init pulse for the classifier.
module image_loader #(
  parameter int LENGTH  = 32,
  parameter int WIDTH   = 32,
  parameter int PIX_W   = 8,
  parameter int THRESH  = 128,
  parameter int MIN_GAP = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [PIX_W-1:0]               pix_data,
  input  logic                           pix_sof,
  output logic [LENGTH-1:0][WIDTH-1:0]   image_out,
  output logic                           init_out,
  output logic [15:0]                    frame_cnt,
  output logic                           sof_err
);

  localparam int RW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = $clog2(MIN_GAP + 1);

  typedef enum logic [1:0] {IDLE, FILL, GAP} state_t;

  state_t                        state_reg, state_next;
  logic [RW-1:0]                 row_reg, row_next;
  logic [CW-1:0]                 col_reg, col_next;
  logic [GW-1:0]                 gap_reg, gap_next;
  logic [LENGTH-1:0][WIDTH-1:0]  shadow_reg, shadow_next, image_reg;
  logic                          init_reg, sof_err_reg, sof_err_next;
  logic [15:0]                   frame_cnt_reg;

  logic          accept, pix_bit, at_last, wr_en, publish;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;

  assign pix_ready = (state_reg != GAP);
  assign accept    = pix_valid && pix_ready;
  assign pix_bit   = (int'(pix_data) >= THRESH);
  assign at_last   = (row_reg == RW'(LENGTH - 1)) && (col_reg == CW'(WIDTH - 1));

  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    gap_next     = gap_reg;
    wr_en        = 1'b0;
    wr_row       = row_reg;
    wr_col       = col_reg;
    publish      = 1'b0;
    sof_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        // Anything before a start-of-frame beat is junk and is consumed without effect.
        if (accept && pix_sof) begin
          wr_en      = 1'b1;
          wr_row     = '0;
          wr_col     = '0;
          state_next = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (pix_sof) begin
            wr_row       = '0;
            wr_col       = '0;
            sof_err_next = 1'b1;
          end else if (at_last) begin
            publish    = 1'b1;
            gap_next   = GW'(MIN_GAP);
            state_next = GAP;
          end
        end
      end
      GAP: begin
        gap_next = gap_reg - 1'b1;
        if (gap_reg == GW'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (publish) begin
      row_next = '0;
      col_next = '0;
    end else if (wr_en) begin
      if (wr_col == CW'(WIDTH - 1)) begin
        col_next = '0;
        row_next = wr_row + 1'b1;
      end else begin
        col_next = wr_col + 1'b1;
        row_next = wr_row;
      end
    end
  end

  // Per-bit write decode so the published frame can include the final pixel on the same edge.
  genvar gi, gj;
  generate
    for (gi = 0; gi < LENGTH; gi++) begin : g_row
      for (gj = 0; gj < WIDTH; gj++) begin : g_col
        assign shadow_next[gi][gj] = (wr_en && wr_row == RW'(gi) && wr_col == CW'(gj))
                                     ? pix_bit : shadow_reg[gi][gj];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    shadow_reg <= shadow_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      row_reg       <= '0;
      col_reg       <= '0;
      gap_reg       <= '0;
      image_reg     <= '0;
      init_reg      <= 1'b0;
      sof_err_reg   <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      gap_reg     <= gap_next;
      init_reg    <= publish;
      sof_err_reg <= sof_err_next;
      if (publish) begin
        image_reg     <= shadow_next;
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign image_out = image_reg;
  assign init_out  = init_reg;
  assign sof_err   = sof_err_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_image_loader.sv
// Randomized self-checking bench for image_loader; expected frames are rebuilt
// from the list of pixels sent, mapping beat k to (k / WIDTH, k % WIDTH).
module tb_image_loader;

  localparam int L  = 32;
  localparam int W  = 32;
  localparam int PW = 8;
  localparam int TH = 128;
  localparam int MG = 2;
  localparam int N  = L * W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  pix_valid = 1'b0;
  logic                  pix_ready;
  logic [PW-1:0]         pix_data = '0;
  logic                  pix_sof = 1'b0;
  logic [L-1:0][W-1:0]   image_out;
  logic                  init_out;
  logic [15:0]           frame_cnt;
  logic                  sof_err;

  int checks = 0;
  int failures = 0;
  int init_cnt = 0;
  int sof_cnt = 0;
  int q[$];

  always #5 clk = ~clk;

  image_loader #(.LENGTH(L), .WIDTH(W), .PIX_W(PW), .THRESH(TH), .MIN_GAP(MG)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .image_out(image_out),
    .init_out(init_out), .frame_cnt(frame_cnt), .sof_err(sof_err)
  );

  // Background monitor: pulse counting, no init/sof_err overlap, image_out stable between pulses.
  logic [L-1:0][W-1:0] prev_img;
  logic                rst_prev = 1'b1;
  bit                  mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      checks = checks + 2;
      if (init_out && sof_err) begin
        failures++;
        $display("FAIL overlap init_out=%0b sof_err=%0b required not both 1", init_out, sof_err);
      end
      if (!init_out && !rst_prev && image_out !== prev_img) begin
        failures++;
        $display("FAIL image_stable image_out changed without init_out at %0t", $time);
      end
    end
    if (init_out) init_cnt++;
    if (sof_err) sof_cnt++;
    prev_img = image_out;
    rst_prev = rst;
  end

  function automatic logic [L-1:0][W-1:0] model_img();
    logic [L-1:0][W-1:0] m = '0;
    for (int k = 0; k < q.size() && k < N; k++) m[k / W][k % W] = (q[k] >= TH);
    return m;
  endfunction

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) begin
      pix_sof  = 1'($urandom_range(0, 1));  // SOF without valid must be ignored
      pix_data = PW'($urandom);
      @(posedge clk); #1;
    end
    pix_sof = 1'b0;
  endtask

  task automatic send_beat(input int data, input bit sof, input int max_idle, output int waits);
    bit acc;
    int g;
    g = (max_idle > 0) ? $urandom_range(0, max_idle) : 0;
    if (g > 0) idle(g);
    pix_valid = 1'b1;
    pix_data  = data[PW-1:0];
    pix_sof   = sof;
    waits     = 0;
    while (1) begin
      acc = pix_ready;
      @(posedge clk); #1;
      if (acc) break;
      waits++;
      if (waits > 50) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout pix_ready low for %0d cycles, required accept within 50", waits);
        break;
      end
    end
  endtask

  task automatic send_q(input int from, input int to, input int max_idle, output int first_waits);
    int w;
    first_waits = 0;
    for (int k = from; k < to; k++) begin
      send_beat(q[k], k == 0, max_idle, w);
      if (k == from) first_waits = w;
    end
  endtask

  task automatic fill_random(input int n);
    q.delete();
    for (int k = 0; k < n; k++) q.push_back($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_valid = 1'($urandom_range(0, 1));
    pix_sof = 1'($urandom_range(0, 1));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    checks = checks + 5;
    if (image_out !== '0) begin failures++; $display("FAIL reset_image got=%0h required=0", image_out); end
    if (init_out !== 1'b0) begin failures++; $display("FAIL reset_init got=%0b required=0", init_out); end
    if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d required=0", frame_cnt); end
    if (pix_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b required=1", pix_ready); end
    if (sof_err !== 1'b0) begin failures++; $display("FAIL reset_sof_err got=%0b required=0", sof_err); end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_full_frame();
    int w, low, i0;
    do_reset();
    i0 = init_cnt;
    q.delete();
    for (int k = 0; k < N; k++) q.push_back((k == 5 * W + 7 || k == N - 1) ? 200 : 10);
    send_q(0, N, 0, w);
    pix_valid = 1'b0;
    checks = checks + 6;
    if (init_out !== 1'b1) begin failures++; $display("FAIL full_init got=%0b required=1", init_out); end
    if (image_out[5][7] !== 1'b1) begin failures++; $display("FAIL full_bit_5_7 got=%0b required=1", image_out[5][7]); end
    if (image_out[31][31] !== 1'b1) begin failures++; $display("FAIL full_bit_31_31 got=%0b required=1", image_out[31][31]); end
    if ($countones(image_out) != 2) begin failures++; $display("FAIL full_popcount got=%0d required=2", $countones(image_out)); end
    if (frame_cnt !== 16'd1) begin failures++; $display("FAIL full_frame_cnt got=%0d required=1", frame_cnt); end
    if (image_out !== model_img()) begin failures++; $display("FAIL full_image got=%0h required=%0h", image_out, model_img()); end
    low = 0;
    for (int i = 0; i < 10; i++) begin
      if (pix_ready) break;
      low++;
      @(posedge clk); #1;
    end
    checks = checks + 2;
    if (low != MG) begin failures++; $display("FAIL full_gap_len got=%0d required=%0d", low, MG); end
    if (init_cnt - i0 != 1) begin failures++; $display("FAIL full_init_pulses got=%0d required=1", init_cnt - i0); end
    $display("test_full_frame done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_threshold();
    int w;
    do_reset();
    fill_random(N);
    q[0] = TH;
    q[1] = TH - 1;
    send_q(0, N, 1, w);
    pix_valid = 1'b0;
    checks = checks + 4;
    if (image_out[0][0] !== 1'b1) begin failures++; $display("FAIL thresh_eq got=%0b required=1", image_out[0][0]); end
    if (image_out[0][1] !== 1'b0) begin failures++; $display("FAIL thresh_below got=%0b required=0", image_out[0][1]); end
    if (image_out !== model_img()) begin failures++; $display("FAIL thresh_image got=%0h required=%0h", image_out, model_img()); end
    if (init_out !== 1'b1) begin failures++; $display("FAIL thresh_init got=%0b required=1", init_out); end
    idle(4);
    $display("test_threshold done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_mid_sof();
    int w, s0, i0;
    do_reset();
    s0 = sof_cnt;
    i0 = init_cnt;
    fill_random(500);
    send_q(0, 500, 1, w);
    fill_random(N);
    send_beat(q[0], 1'b1, 0, w);
    checks = checks + 2;
    if (sof_err !== 1'b1) begin failures++; $display("FAIL midsof_err got=%0b required=1", sof_err); end
    if (init_out !== 1'b0) begin failures++; $display("FAIL midsof_init got=%0b required=0", init_out); end
    send_q(1, N, 1, w);
    pix_valid = 1'b0;
    checks = checks + 3;
    if (init_out !== 1'b1) begin failures++; $display("FAIL midsof_final_init got=%0b required=1", init_out); end
    if (image_out !== model_img()) begin failures++; $display("FAIL midsof_image got=%0h required=%0h", image_out, model_img()); end
    if (frame_cnt !== 16'd1) begin failures++; $display("FAIL midsof_frame_cnt got=%0d required=1", frame_cnt); end
    idle(4);
    checks = checks + 2;
    if (sof_cnt - s0 != 1) begin failures++; $display("FAIL midsof_err_pulses got=%0d required=1", sof_cnt - s0); end
    if (init_cnt - i0 != 1) begin failures++; $display("FAIL midsof_init_pulses got=%0d required=1", init_cnt - i0); end
    $display("test_mid_sof done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_junk_backpressure();
    int w, i0;
    do_reset();
    i0 = init_cnt;
    for (int k = 0; k < 20; k++) send_beat($urandom_range(0, 255), 1'b0, 2, w);
    fill_random(N);
    send_q(0, N, 3, w);
    checks = checks + 3;
    if (init_out !== 1'b1) begin failures++; $display("FAIL junk_init got=%0b required=1", init_out); end
    if (image_out !== model_img()) begin failures++; $display("FAIL junk_image got=%0h required=%0h", image_out, model_img()); end
    if (frame_cnt !== 16'd1) begin failures++; $display("FAIL junk_frame_cnt got=%0d required=1", frame_cnt); end
    // pix_valid stays high into GAP: the next SOF beat must wait exactly MIN_GAP cycles.
    fill_random(N);
    send_q(0, N, 0, w);
    pix_valid = 1'b0;
    checks = checks + 3;
    if (w != MG) begin failures++; $display("FAIL back_to_back_wait got=%0d required=%0d", w, MG); end
    if (image_out !== model_img()) begin failures++; $display("FAIL back_to_back_image got=%0h required=%0h", image_out, model_img()); end
    if (frame_cnt !== 16'd2) begin failures++; $display("FAIL back_to_back_frame_cnt got=%0d required=2", frame_cnt); end
    idle(4);
    checks++;
    if (init_cnt - i0 != 2) begin failures++; $display("FAIL junk_init_pulses got=%0d required=2", init_cnt - i0); end
    $display("test_junk_backpressure done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid_frame();
    int w, i0;
    do_reset();
    fill_random(N);
    send_q(0, N, 0, w);
    idle(4);
    i0 = init_cnt;
    fill_random(N);
    send_q(0, 600, 1, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pix_valid = 1'b0;
    checks = checks + 4;
    if (image_out !== '0) begin failures++; $display("FAIL rstmid_image got=%0h required=0", image_out); end
    if (frame_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_frame_cnt got=%0d required=0", frame_cnt); end
    if (pix_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0b required=1", pix_ready); end
    if (init_out !== 1'b0) begin failures++; $display("FAIL rstmid_init got=%0b required=0", init_out); end
    idle(3);
    checks++;
    if (init_cnt != i0) begin failures++; $display("FAIL rstmid_no_init got=%0d required=%0d", init_cnt, i0); end
    fill_random(N);
    send_q(0, N, 1, w);
    pix_valid = 1'b0;
    checks = checks + 3;
    if (init_out !== 1'b1) begin failures++; $display("FAIL rstmid_next_init got=%0b required=1", init_out); end
    if (image_out !== model_img()) begin failures++; $display("FAIL rstmid_next_image got=%0h required=%0h", image_out, model_img()); end
    if (frame_cnt !== 16'd1) begin failures++; $display("FAIL rstmid_next_frame_cnt got=%0d required=1", frame_cnt); end
    idle(4);
    $display("test_reset_mid_frame done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_threshold();
    test_mid_sof();
    test_junk_backpressure();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
